// File: rtl/gf2_pkg.sv
// Shared constants and types for the GF(2) carry-less multiply-accumulate unit.
package gf2_pkg;

  // Accumulation mode carried by each input beat.
  typedef enum logic {
    ACC_OFF = 1'b0,
    ACC_ON  = 1'b1
  } acc_mode_e;

  // Width of a W x W carry-less product: degrees 0 .. 2W-2.
  function automatic int prod_w(input int w);
    return 2 * w - 1;
  endfunction

endpackage

// File: rtl/gf2_clmul_mac_if.sv
// Beat/result handshake bundle between a producer/consumer and gf2_clmul_mac.
interface gf2_clmul_mac_if
  import gf2_pkg::*;
#(
  parameter int W     = 8,
  parameter int NCH   = 2,
  parameter int OUT_W = 7
);
  localparam int PROD_W = prod_w(W);

  logic              in_valid;
  logic              in_ready;
  logic [NCH*W-1:0]  a;
  logic [NCH*W-1:0]  b;
  logic              acc_mode;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  y;
  logic [PROD_W-1:0] y_full;

  modport master (
    output in_valid, a, b, acc_mode, in_last, out_ready,
    input  in_ready, out_valid, y, y_full
  );

  modport slave (
    input  in_valid, a, b, acc_mode, in_last, out_ready,
    output in_ready, out_valid, y, y_full
  );
endinterface

// File: rtl/gf2_clmul_lane.sv
// Combinational W x W carry-less (GF(2) polynomial) multiplier.
module gf2_clmul_lane
  import gf2_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]         a_i,
  input  logic [W-1:0]         b_i,
  output logic [prod_w(W)-1:0] p_o
);
  localparam int PROD_W = prod_w(W);

  // XOR together b shifted by every set bit of a; no carries propagate.
  always_comb begin
    p_o = '0;
    for (int i = 0; i < W; i++) begin
      if (a_i[i]) begin
        p_o = p_o ^ (PROD_W'(b_i) << i);
      end
    end
  end
endmodule

// File: rtl/gf2_clmul_mac.sv
// Two-stage pipelined GF(2) multiply-accumulate: S1 holds per-channel
// products, S2 XOR-reduces them, folds frames into the accumulator and
// registers the windowed result. A single global stall freezes everything.
module gf2_clmul_mac
  import gf2_pkg::*;
#(
  parameter int W      = 8,
  parameter int NCH    = 2,
  parameter int OUT_W  = 7,
  parameter int OFFSET = 3
) (
  input logic            clk,
  input logic            rst_n,
  gf2_clmul_mac_if.slave bus
);
  localparam int PROD_W = prod_w(W);

  logic [PROD_W-1:0] prod_d [NCH];
  logic [PROD_W-1:0] prod_q [NCH];
  logic              v1_q;
  acc_mode_e         mode1_q;
  logic              last1_q;

  logic [PROD_W-1:0] acc_q;
  logic              open_q;
  logic              out_valid_q;
  logic [OUT_W-1:0]  y_q;
  logic [PROD_W-1:0] y_full_q;

  logic              advance;
  logic [PROD_W-1:0] sum_d;
  logic [PROD_W-1:0] acc_d;
  logic [PROD_W-1:0] res_d;
  logic              emit_d;
  logic [OUT_W-1:0]  win_d;

  // The pipeline moves only when the output register is free or being drained.
  assign advance      = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready = rst_n && advance;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_lane
      gf2_clmul_lane #(.W(W)) u_lane (
        .a_i (bus.a[gi*W +: W]),
        .b_i (bus.b[gi*W +: W]),
        .p_o (prod_d[gi])
      );
    end
  endgenerate

  // S1: capture the per-channel products and the beat's control bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      mode1_q <= ACC_OFF;
      last1_q <= 1'b0;
      for (int c = 0; c < NCH; c++) prod_q[c] <= '0;
    end else if (advance) begin
      v1_q    <= bus.in_valid;
      mode1_q <= acc_mode_e'(bus.acc_mode);
      last1_q <= bus.in_last;
      for (int c = 0; c < NCH; c++) prod_q[c] <= prod_d[c];
    end
  end

  // XOR-reduce the channels, form the running frame value and decide emission.
  always_comb begin
    sum_d = '0;
    for (int c = 0; c < NCH; c++) sum_d = sum_d ^ prod_q[c];
    acc_d  = (open_q ? acc_q : '0) ^ sum_d;
    emit_d = v1_q && ((mode1_q == ACC_OFF) || last1_q);
    res_d  = (mode1_q == ACC_OFF) ? sum_d : acc_d;
  end

  // Output window; positions past the top of the product read as zero.
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_win
      if (OFFSET + gi < PROD_W) begin : g_in
        assign win_d[gi] = res_d[OFFSET+gi];
      end else begin : g_zero
        assign win_d[gi] = 1'b0;
      end
    end
  endgenerate

  // S2: update frame state (accumulate beats only) and the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      open_q      <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      y_full_q    <= '0;
    end else if (advance) begin
      out_valid_q <= emit_d;
      if (emit_d) begin
        y_q      <= win_d;
        y_full_q <= res_d;
      end
      if (v1_q && (mode1_q == ACC_ON)) begin
        if (last1_q) begin
          acc_q  <= '0;
          open_q <= 1'b0;
        end else begin
          acc_q  <= acc_d;
          open_q <= 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.y_full    = y_full_q;
endmodule

// File: tb/tb_gf2_clmul_mac.sv
// Self-checking bench for gf2_clmul_mac with default parameters
// (W=8, NCH=2, OUT_W=7, OFFSET=3) against a behavioural model.
module tb_gf2_clmul_mac;
  localparam int W      = 8;
  localparam int NCH    = 2;
  localparam int OUT_W  = 7;
  localparam int OFFSET = 3;

  logic clk;
  logic rst_n;

  gf2_clmul_mac_if #(.W(W), .NCH(NCH), .OUT_W(OUT_W)) bus ();

  gf2_clmul_mac #(.W(W), .NCH(NCH), .OUT_W(OUT_W), .OFFSET(OFFSET)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur within its bound (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Polynomial product over GF(2) straight from the definition.
  function automatic int unsigned clmul(input int unsigned x, input int unsigned z);
    int unsigned r = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (x[i] && z[j]) r = r ^ (32'd1 << (i + j));
    return r;
  endfunction

  function automatic int unsigned window(input int unsigned s);
    return (s >> OFFSET) & ((32'd1 << OUT_W) - 1);
  endfunction

  typedef struct {
    int unsigned val;
    int unsigned stamp;
    bit          lat;
  } exp_t;

  exp_t        q[$];
  int unsigned m_acc  = 0;
  bit          m_open = 0;
  int unsigned cyc    = 0;
  bit          rst_edge = 0;
  bit          lat_mode = 0;
  int          stream_seen = 0;

  // Just before each rising edge: apply reset or an accepted beat to the model.
  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      q.delete();
      m_acc    = 0;
      m_open   = 0;
      rst_edge = 1;
    end else begin
      rst_edge = 0;
      if (bus.in_valid && bus.in_ready) begin
        int unsigned s;
        exp_t e;
        s = 0;
        for (int c = 0; c < NCH; c++)
          s = s ^ clmul(32'(bus.a[c*W +: W]), 32'(bus.b[c*W +: W]));
        e.stamp = cyc;
        e.lat   = lat_mode;
        if (!bus.acc_mode) begin
          e.val = s;
          q.push_back(e);
        end else begin
          int unsigned nxt;
          nxt = (m_open ? m_acc : 0) ^ s;
          if (bus.in_last) begin
            e.val = nxt;
            q.push_back(e);
            m_acc  = 0;
            m_open = 0;
          end else begin
            m_acc  = nxt;
            m_open = 1;
          end
        end
      end
    end
    cyc++;
  end

  // Output checker: every cycle the outputs are meaningful.
  always @(negedge clk) begin
    #2;
    if (rst_edge) begin
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_y", 32'(bus.y), 0);
      chk("rst_y_full", 32'(bus.y_full), 0);
      if (!rst_n) chk("rst_in_ready", 32'(bus.in_ready), 0);
    end else if (bus.out_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got y_full=0x%0h with no result pending (t=%0t)",
                 bus.y_full, $time);
      end else begin
        exp_t e;
        e = q[0];
        chk("y_full", 32'(bus.y_full), e.val);
        chk("y", 32'(bus.y), window(e.val));
        if (bus.out_ready) begin
          if (e.lat) begin
            chk("stream_latency", cyc - e.stamp, 2);
            stream_seen++;
          end
          void'(q.pop_front());
        end else begin
          chk("stall_in_ready", 32'(bus.in_ready), 0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] a0, input logic [7:0] b0,
                      input logic [7:0] a1, input logic [7:0] b1,
                      input bit mode, input bit last);
    int n = 0;
    bus.a        = {a1, a0};
    bus.b        = {b1, b0};
    bus.acc_mode = mode;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) fail_now("send_in_ready");
    @(negedge clk);
  endtask

  task automatic wait_out(input string name, input int unsigned ef, input int unsigned ey);
    bit got = 0;
    bus.in_valid = 1'b0;
    for (int n = 0; n < 12 && !got; n++) begin
      @(negedge clk);
      #3;
      if (bus.out_valid) begin
        got = 1;
        chk({name, "_full"}, 32'(bus.y_full), ef);
        chk({name, "_y"}, 32'(bus.y), ey);
      end
    end
    if (!got) fail_now({name, "_timeout"});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.acc_mode = 1'b0;
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b1;

    // Hand-computed products pin the model itself.
    chk("model_3x3", clmul(32'h03, 32'h03), 32'h0005);
    chk("model_ffxff", clmul(32'hFF, 32'hFF), 32'h5555);
    chk("model_1x5", clmul(32'h01, 32'h05), 32'h0005);
    chk("model_2x3", clmul(32'h02, 32'h03), 32'h0006);
    chk("model_window_5555", window(32'h5555), 32'h2A);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Per-beat products (channel 1 idle).
    send(8'h03, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_out("beat_3x3", 32'h0005, 32'h00);
    send(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
    // 0x5555 has even bits set; the window starting at bit 3 gives 0101010b.
    wait_out("beat_ffxff", 32'h5555, 32'h2A);

    // Two-channel cancellation.
    send(8'h03, 8'h03, 8'h01, 8'h05, 1'b0, 1'b0);
    wait_out("cancel", 32'h0000, 32'h00);
    send(8'h03, 8'h03, 8'h00, 8'h05, 1'b0, 1'b0);
    wait_out("cancel_a1_zero", 32'h0005, 32'h00);

    // Frame accumulation: 5 ^ 6 ^ 3 = 0, then 5 ^ 6 ^ 1 = 2.
    send(8'h03, 8'h03, 8'h00, 8'h00, 1'b1, 1'b0);
    send(8'h02, 8'h03, 8'h00, 8'h00, 1'b1, 1'b0);
    send(8'h01, 8'h03, 8'h00, 8'h00, 1'b1, 1'b1);
    wait_out("frame_zero", 32'h0000, 32'h00);
    send(8'h03, 8'h03, 8'h00, 8'h00, 1'b1, 1'b0);
    send(8'h02, 8'h03, 8'h00, 8'h00, 1'b1, 1'b0);
    idle(2);
    send(8'h01, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1);
    wait_out("frame_two", 32'h0002, 32'h00);

    // Backpressure: output held for several cycles, extra beats queue behind it.
    idle(2);
    bus.out_ready = 1'b0;
    fork
      begin
        send(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
          send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        bus.in_valid = 1'b0;
      end
      begin
        int n = 0;
        #3;
        while (!bus.out_valid && n < 20) begin
          @(negedge clk);
          #3;
          n++;
        end
        if (!bus.out_valid) fail_now("bp_first_output");
        for (int k = 0; k < 5; k++) begin
          chk("bp_hold_y", 32'(bus.y), 32'h2A);
          chk("bp_hold_full", 32'(bus.y_full), 32'h5555);
          chk("bp_in_ready", 32'(bus.in_ready), 0);
          @(negedge clk);
          #3;
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    idle(8);
    chk("bp_drained", q.size(), 0);

    // Back-to-back streaming with fixed latency and no bubbles.
    lat_mode = 1;
    for (int k = 0; k < 16; k++)
      send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    lat_mode = 0;
    idle(6);
    chk("stream_count", 32'(stream_seen), 16);

    // Reset mid-frame and mid-pipeline: acc 5^6=3 pending, one beat in S1.
    send(8'h03, 8'h03, 8'h00, 8'h00, 1'b1, 1'b0);
    send(8'h02, 8'h03, 8'h00, 8'h00, 1'b1, 1'b0);
    send(8'h01, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    send(8'h02, 8'h03, 8'h00, 8'h00, 1'b1, 1'b1);
    wait_out("after_reset", 32'h0006, 32'h00);

    // Random mix of modes, frames, bubbles and backpressure.
    begin
      bit run = 1;
      fork
        begin
          for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
          end
          bus.in_valid = 1'b0;
          run = 0;
        end
        begin
          while (run) begin
            @(negedge clk);
            bus.out_ready = ($urandom_range(0, 3) != 0);
          end
          bus.out_ready = 1'b1;
        end
      join
    end
    idle(10);
    chk("final_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    fail_now("watchdog");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
